// File: rtl/ifetch_unit.sv
// ifetch_unit: prefetching fetch stage that streams imem words into a FIFO and issues opcode pairs.
// Define IFETCH_HALT_DETECT_EN to stop fetching at the first HALT_OPCODE word.
module ifetch_unit #(
   parameter int unsigned           INST_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 16,
   parameter int unsigned           FIFO_DEPTH  = 4,
   parameter logic [INST_WIDTH-1:0] NOP_WORD    = '0,
   parameter logic [7:0]            HALT_OPCODE = 8'hFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] inst_count,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rsp_vld,
   input  logic [INST_WIDTH-1:0] imem_rsp_data,
   output logic                  opcode_vld,
   output logic [INST_WIDTH-1:0] opcode0,
   output logic [INST_WIDTH-1:0] opcode1,
   input  logic                  inst_buff_full,
   output logic                  busy,
   output logic                  done
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
`ifdef IFETCH_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] req_left, req_left_nxt, addr_nxt;
   logic [CW-1:0]         outstanding, outst_nxt;
   logic [CW-1:0]         fifo_count, count_nxt;
   logic [CW:0]           level_nxt;
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [INST_WIDTH-1:0] mem [FIFO_DEPTH];
   logic                  halted, halted_nxt;
   logic                  req_nxt, done_nxt;
   logic                  gnt, rsp_ok, push, halt_hit;
   logic                  pair, tail, issue;

   always_comb begin
      state_nxt    = state;
      req_left_nxt = req_left;
      addr_nxt     = imem_addr;
      halted_nxt   = halted;
      done_nxt     = 1'b0;
      gnt      = imem_req && imem_gnt;
      rsp_ok   = imem_rsp_vld && (outstanding != '0);
      push     = rsp_ok && !halted;
      halt_hit = HALT_EN && push &&
                 (imem_rsp_data[INST_WIDTH-1 -: 8] == HALT_OPCODE);
      pair  = fifo_count >= CW'(2);
      tail  = (fifo_count == CW'(1)) && (req_left == '0) &&
              (outstanding == '0);
      issue = !inst_buff_full && !opcode_vld && (pair || tail);
      if (gnt) begin
         req_left_nxt = req_left - ADDR_WIDTH'(1);
         addr_nxt     = imem_addr + ADDR_WIDTH'(1);
      end
      unique case (state)
         IDLE: begin
            if (start && inst_count != '0) begin
               state_nxt    = FETCH;
               req_left_nxt = inst_count;
               addr_nxt     = start_addr;
               halted_nxt   = 1'b0;
            end else if (start) begin
               done_nxt = 1'b1;
            end
         end
         FETCH: begin
            if (gnt && req_left == ADDR_WIDTH'(1))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (outstanding == '0 && fifo_count == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // a halt word cuts the run short; later responses are drained, not kept
      if (halt_hit) begin
         req_left_nxt = '0;
         halted_nxt   = 1'b1;
         if (state == FETCH)
            state_nxt = DRAIN;
      end
      outst_nxt = outstanding + CW'(gnt) - CW'(rsp_ok);
      count_nxt = fifo_count + CW'(push) -
                  (issue ? (pair ? CW'(2) : CW'(1)) : CW'(0));
      level_nxt = {1'b0, count_nxt} + {1'b0, outst_nxt};
      req_nxt   = (state_nxt == FETCH) && (req_left_nxt != '0) &&
                  (level_nxt < (CW+1)'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         req_left    <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         halted      <= 1'b0;
         imem_req    <= 1'b0;
         imem_addr   <= '0;
         opcode_vld  <= 1'b0;
         opcode0     <= '0;
         opcode1     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         req_left    <= req_left_nxt;
         outstanding <= outst_nxt;
         fifo_count  <= count_nxt;
         halted      <= halted_nxt;
         imem_req    <= req_nxt;
         imem_addr   <= addr_nxt;
         busy        <= state_nxt != IDLE;
         done        <= done_nxt;
         opcode_vld  <= issue;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (issue) begin
            opcode0 <= mem[rd_ptr];
            opcode1 <= pair ? mem[rd_ptr + PW'(1)] : NOP_WORD;
            rd_ptr  <= rd_ptr + (pair ? PW'(2) : PW'(1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= imem_rsp_data;
   end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit with an in-order,
// variable-latency instruction memory model.
module tb_ifetch_unit;
   localparam int AW = 16;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] inst_count = '0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt = 1'b0;
   logic          imem_rsp_vld = 1'b0;
   logic [IW-1:0] imem_rsp_data = '0;
   logic          opcode_vld;
   logic [IW-1:0] opcode0, opcode1;
   logic          inst_buff_full = 1'b0;
   logic          busy, done;

   ifetch_unit dut (
      .clk(clk), .reset(reset), .start(start),
      .start_addr(start_addr), .inst_count(inst_count),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rsp_vld(imem_rsp_vld),
      .imem_rsp_data(imem_rsp_data), .opcode_vld(opcode_vld),
      .opcode0(opcode0), .opcode1(opcode1),
      .inst_buff_full(inst_buff_full), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } pend_t;

   int            ncyc = 0;
   int            lat = 1;
   bit            gnt_alt = 1'b0;
   bit            halt_on = 1'b0;
   logic [AW-1:0] halt_addr = '0;
   pend_t         pend[$];
   logic [AW-1:0] gnt_log[$];
   logic [63:0]   sb[$];

   function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
      if (halt_on && a == halt_addr) return 32'hFF00_0000;
      return {8'h40, a[7:0] ^ 8'h5A, a};
   endfunction

   // memory: grants decided for the coming edge, data returned lat edges later
   always @(negedge clk) begin
      pend_t p;
      ncyc++;
      imem_rsp_vld = 1'b0;
      if (pend.size() > 0 && pend[0].due == ncyc) begin
         imem_rsp_vld  = 1'b1;
         imem_rsp_data = word(pend[0].addr);
         void'(pend.pop_front());
      end
      imem_gnt = gnt_alt ? ((ncyc % 2) == 0) : 1'b1;
      if (imem_req && imem_gnt && !reset) begin
         p.addr = imem_addr;
         p.due  = ncyc + lat;
         pend.push_back(p);
         gnt_log.push_back(imem_addr);
      end
   end

   task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] n);
      logic [IW-1:0] w[$];
      logic [IW-1:0] t;
      for (int i = 0; i < int'(n); i++) begin
         t = word(a + AW'(i));
         w.push_back(t);
`ifdef IFETCH_HALT_DETECT_EN
         if (t[31:24] == 8'hFF) break;
`endif
      end
      for (int i = 0; i < w.size(); i += 2)
         sb.push_back({w[i], (i + 1 < w.size()) ? w[i+1] : 32'h0});
      @(negedge clk); #1;
      start = 1'b1; start_addr = a; inst_count = n;
      gnt_log.delete();
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      total++;
      if ({imem_req, imem_addr, opcode_vld, opcode0, opcode1, busy, done} !== '0)
         $display("FAIL reset_state got req=%b addr=%h vld=%b op0=%h op1=%h busy=%b done=%b required all 0",
                  imem_req, imem_addr, opcode_vld, opcode0, opcode1, busy, done);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_even();
      int last = -10;
      bit seen = 0;
      bit ok = 1;
      lat = 1; gnt_alt = 0;
      do_start(16'h0010, 16'd4);
      total++;
      if ({busy, imem_req, imem_addr} !== {1'b1, 1'b1, 16'h0010})
         $display("FAIL start_timing got busy=%b req=%b addr=%h required 1 1 0010",
                  busy, imem_req, imem_addr);
      else passed++;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk); #1;
         if (opcode_vld) begin
            total++;
            if (sb.size() == 0 || {opcode0, opcode1} !== sb[0])
               $display("FAIL even_pair got %h required %h", {opcode0, opcode1},
                        sb.size() > 0 ? sb[0] : 64'hx);
            else passed++;
            if (sb.size() > 0) void'(sb.pop_front());
            last = c;
         end
         if (done) begin
            seen = 1;
            total++;
            if (c != last + 1 || busy !== 1'b0)
               $display("FAIL even_done_timing got gap=%0d busy=%b required 1 0", c - last, busy);
            else passed++;
         end
      end
      total++;
      if (!seen || sb.size() != 0)
         $display("FAIL even_complete got done=%0d left=%0d required 1 0", seen, sb.size());
      else passed++;
      if (gnt_log.size() != 4) ok = 0;
      foreach (gnt_log[i]) if (gnt_log[i] !== 16'h0010 + AW'(i)) ok = 0;
      total++;
      if (!ok) $display("FAIL even_addrs got %0d grants required 0010..0013", gnt_log.size());
      else passed++;
   endtask

   task automatic test_odd();
      bit seen = 0;
      do_start(16'h0020, 16'd3);
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk); #1;
         if (opcode_vld) begin
            total++;
            if (sb.size() == 0 || {opcode0, opcode1} !== sb[0])
               $display("FAIL odd_pair got %h required %h", {opcode0, opcode1},
                        sb.size() > 0 ? sb[0] : 64'hx);
            else passed++;
            if (sb.size() > 0) void'(sb.pop_front());
         end
         if (done) seen = 1;
      end
      total++;
      if (!seen || sb.size() != 0)
         $display("FAIL odd_complete got done=%0d left=%0d required 1 0", seen, sb.size());
      else passed++;
   endtask

   task automatic test_backpressure();
      bit vld_seen = 0;
      bit seen = 0;
      bit prev = 0;
      bit b2b = 0;
      inst_buff_full = 1'b1;
      do_start(16'h0040, 16'd8);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (opcode_vld) vld_seen = 1;
      end
      total++;
      if (gnt_log.size() != 4 || imem_req !== 1'b0 || vld_seen)
         $display("FAIL bp_hold got grants=%0d req=%b vld=%0d required 4 0 0",
                  gnt_log.size(), imem_req, vld_seen);
      else passed++;
      inst_buff_full = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk); #1;
         if (opcode_vld && prev) b2b = 1;
         prev = opcode_vld;
         if (opcode_vld) begin
            total++;
            if (sb.size() == 0 || {opcode0, opcode1} !== sb[0])
               $display("FAIL bp_pair got %h required %h", {opcode0, opcode1},
                        sb.size() > 0 ? sb[0] : 64'hx);
            else passed++;
            if (sb.size() > 0) void'(sb.pop_front());
         end
         if (done) seen = 1;
      end
      total++;
      if (!seen || sb.size() != 0 || b2b)
         $display("FAIL bp_complete got done=%0d left=%0d b2b=%0d required 1 0 0",
                  seen, sb.size(), b2b);
      else passed++;
   endtask

   task automatic test_stall_wrap();
      bit seen = 0;
      bit held = 1;
      bit ok = 1;
      logic p_req = 0, p_gnt = 0;
      logic [AW-1:0] p_addr = '0;
      lat = 3; gnt_alt = 1;
      do_start(16'hFFFE, 16'd4);
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk); #1;
         if (p_req && !p_gnt && (imem_req !== 1'b1 || imem_addr !== p_addr)) held = 0;
         p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr;
         if (opcode_vld) begin
            total++;
            if (sb.size() == 0 || {opcode0, opcode1} !== sb[0])
               $display("FAIL wrap_pair got %h required %h", {opcode0, opcode1},
                        sb.size() > 0 ? sb[0] : 64'hx);
            else passed++;
            if (sb.size() > 0) void'(sb.pop_front());
         end
         if (done) seen = 1;
      end
      if (gnt_log.size() != 4) ok = 0;
      foreach (gnt_log[i]) if (gnt_log[i] !== 16'hFFFE + AW'(i)) ok = 0;
      total++;
      if (!ok || !held)
         $display("FAIL wrap_addrs got grants=%0d held=%0d required 4 1", gnt_log.size(), held);
      else passed++;
      total++;
      if (!seen || sb.size() != 0)
         $display("FAIL wrap_complete got done=%0d left=%0d required 1 0", seen, sb.size());
      else passed++;
      lat = 1; gnt_alt = 0;
   endtask

   task automatic test_reset_midrun();
      bit seen = 0;
      bit stray = 0;
      lat = 4;
      do_start(16'h0080, 16'd8);
      for (int c = 0; c < 20 && pend.size() < 2; c++) begin
         @(negedge clk); #1;
      end
      total++;
      if (pend.size() < 2) $display("FAIL mid_outstanding got %0d required >=2", pend.size());
      else passed++;
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      total++;
      if ({imem_req, imem_addr, opcode_vld, opcode0, opcode1, busy, done} !== '0)
         $display("FAIL mid_reset got req=%b addr=%h vld=%b busy=%b done=%b required all 0",
                  imem_req, imem_addr, opcode_vld, busy, done);
      else passed++;
      sb.delete();
      for (int c = 0; c < 20 && pend.size() > 0; c++) begin
         @(negedge clk); #1;
         if (opcode_vld || busy) stray = 1;
      end
      repeat (3) begin
         @(negedge clk); #1;
         if (opcode_vld || busy) stray = 1;
      end
      total++;
      if (stray || pend.size() != 0)
         $display("FAIL mid_drop got stray=%0d pend=%0d required 0 0", stray, pend.size());
      else passed++;
      lat = 1;
      do_start(16'h0090, 16'd3);
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk); #1;
         if (opcode_vld) begin
            total++;
            if (sb.size() == 0 || {opcode0, opcode1} !== sb[0])
               $display("FAIL mid_pair got %h required %h", {opcode0, opcode1},
                        sb.size() > 0 ? sb[0] : 64'hx);
            else passed++;
            if (sb.size() > 0) void'(sb.pop_front());
         end
         if (done) seen = 1;
      end
      total++;
      if (!seen || sb.size() != 0)
         $display("FAIL mid_complete got done=%0d left=%0d required 1 0", seen, sb.size());
      else passed++;
   endtask

   task automatic test_zero_count();
      do_start(16'h0005, 16'd0);
      total++;
      if ({done, busy, imem_req} !== 3'b100)
         $display("FAIL zero_done got done=%b busy=%b req=%b required 1 0 0", done, busy, imem_req);
      else passed++;
      @(negedge clk); #1;
      total++;
      if ({done, busy} !== 2'b00)
         $display("FAIL zero_pulse got done=%b busy=%b required 0 0", done, busy);
      else passed++;
   endtask

   task automatic test_halt();
      bit seen = 0;
      int exp_grants;
      halt_on = 1; halt_addr = 16'h00A2; lat = 1;
`ifdef IFETCH_HALT_DETECT_EN
      do_start(16'h00A0, 16'd8);
      exp_grants = 4;
`else
      do_start(16'h00A0, 16'd4);
      exp_grants = 4;
`endif
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk); #1;
         if (opcode_vld) begin
            total++;
            if (sb.size() == 0 || {opcode0, opcode1} !== sb[0])
               $display("FAIL halt_pair got %h required %h", {opcode0, opcode1},
                        sb.size() > 0 ? sb[0] : 64'hx);
            else passed++;
            if (sb.size() > 0) void'(sb.pop_front());
         end
         if (done) seen = 1;
      end
      total++;
      if (!seen || sb.size() != 0 || gnt_log.size() != exp_grants)
         $display("FAIL halt_complete got done=%0d left=%0d grants=%0d required 1 0 %0d",
                  seen, sb.size(), gnt_log.size(), exp_grants);
      else passed++;
      halt_on = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      test_even();
      test_odd();
      test_backpressure();
      test_stall_wrap();
      test_reset_midrun();
      test_zero_count();
      test_halt();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
